// File: rtl/dct_pass_sequencer_if.sv
// Stream, coefficient and multiplier-operand signals of the DCT pass sequencer.
// master = sequencer side, slave = surrounding front end / quantiser / multiplier.
interface dct_pass_sequencer_if #(
    parameter int DW = 32,
    parameter int N  = 8
);
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [N*N*DW-1:0] mul_matrix;
    logic              mul_validin;
    logic [N*N*DW-1:0] mul_out;
    logic              mul_validout;

    modport master (
        input  in_data, in_valid, out_ready, mul_out, mul_validout,
        output in_ready, out_data, out_valid, out_last, mul_matrix, mul_validin
    );

    modport slave (
        output in_data, in_valid, out_ready, mul_out, mul_validout,
        input  in_ready, out_data, out_valid, out_last, mul_matrix, mul_validin
    );
endinterface

// File: rtl/dct_pass_sequencer.sv
// Purpose: load an 8x8 float32 block, run two transposed multiplier passes, stream coefficients out.
// Latency: last input word to first output word is 2*L_mul + 4 cycles (counting both end cycles).
// Backpressure: in_ready only in LOAD; out_data held while out_valid & !out_ready. Timeout: DCT_SEQ_TIMEOUT_EN.
module dct_pass_sequencer #(
    parameter int DW = 32,
    parameter int N  = 8
`ifdef DCT_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    dct_pass_sequencer_if.master bus,
    output logic                 busy
`ifdef DCT_SEQ_TIMEOUT_EN
    ,
    output logic                 err
`endif
);
    localparam int WORDS = N * N;
    localparam int CW    = $clog2(WORDS);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic [2:0] {
        LOAD, ISSUE1, WAIT1, ISSUE2, WAIT2, DRAIN
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [WORDS*DW-1:0] blk;
`ifdef DCT_SEQ_TIMEOUT_EN
    logic [10:0]         wcnt;
`endif

    assign bus.mul_matrix = blk;
    assign bus.out_data   = blk[int'(cnt)*DW +: DW];

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= LOAD;
            cnt             <= '0;
            bus.in_ready    <= 1'b1;
            bus.out_valid   <= 1'b0;
            bus.out_last    <= 1'b0;
            bus.mul_validin <= 1'b0;
            busy            <= 1'b0;
`ifdef DCT_SEQ_TIMEOUT_EN
            err             <= 1'b0;
            wcnt            <= '0;
`endif
        end else begin
            bus.mul_validin <= 1'b0;
            case (state)
                LOAD: begin
                    if (bus.in_valid && bus.in_ready) begin
                        blk[int'(cnt)*DW +: DW] <= bus.in_data;
                        busy <= 1'b1;
                        if (cnt == LAST) begin
                            state           <= ISSUE1;
                            cnt             <= '0;
                            bus.in_ready    <= 1'b0;
                            bus.mul_validin <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ISSUE1, ISSUE2: begin
                    state <= (state == ISSUE1) ? WAIT1 : WAIT2;
`ifdef DCT_SEQ_TIMEOUT_EN
                    wcnt  <= '0;
`endif
                end
                WAIT1, WAIT2: begin
                    if (bus.mul_validout) begin
                        // Every pass result is stored transposed, so two passes give row then column DCT.
                        for (int r = 0; r < N; r++) begin
                            for (int c = 0; c < N; c++) begin
                                blk[(r*N+c)*DW +: DW] <= bus.mul_out[(c*N+r)*DW +: DW];
                            end
                        end
                        if (state == WAIT1) begin
                            state           <= ISSUE2;
                            bus.mul_validin <= 1'b1;
                        end else begin
                            state         <= DRAIN;
                            cnt           <= '0;
                            bus.out_valid <= 1'b1;
                            bus.out_last  <= (LAST == '0);
                        end
`ifdef DCT_SEQ_TIMEOUT_EN
                    end else if (wcnt == 11'(TIMEOUT_CYC - 1)) begin
                        err          <= 1'b1;
                        state        <= LOAD;
                        cnt          <= '0;
                        bus.in_ready <= 1'b1;
                        busy         <= 1'b0;
                    end else begin
                        wcnt <= wcnt + 1'b1;
`endif
                    end
                end
                DRAIN: begin
                    if (bus.out_valid && bus.out_ready) begin
                        if (cnt == LAST) begin
                            state         <= LOAD;
                            cnt           <= '0;
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            bus.in_ready  <= 1'b1;
                            busy          <= 1'b0;
                        end else begin
                            cnt          <= cnt + 1'b1;
                            bus.out_last <= (cnt == LAST - 1'b1);
                        end
                    end
                end
                default: begin
                    state        <= LOAD;
                    cnt          <= '0;
                    bus.in_ready <= 1'b1;
                    busy         <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dct_pass_sequencer.sv
// Directed bench for dct_pass_sequencer with a 5-cycle multiplier model (echo / index-pattern / silent).
module tb_dct_pass_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
`ifdef DCT_SEQ_TIMEOUT_EN
    logic err;
`endif
    dct_pass_sequencer_if bus();

    int total = 0;
    int bad = 0;
    int mode = 0;      // 0 echo, 1 word k = k, 2 never responds
    int vin_cnt = 0;
    logic spur = 1'b0;
    logic [4:0] pipe = '0;
    logic [2047:0] mo;

    always #5 clk = ~clk;

    dct_pass_sequencer #(
        .DW(32),
        .N(8)
`ifdef DCT_SEQ_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(16)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .busy(busy)
`ifdef DCT_SEQ_TIMEOUT_EN
        ,
        .err(err)
`endif
    );

    always @(posedge clk) begin
        pipe <= {pipe[3:0], bus.mul_validin};
        if (bus.mul_validin) vin_cnt <= vin_cnt + 1;
    end
    assign bus.mul_validout = (pipe[4] && mode != 2) || spur;

    always_comb begin
        mo = bus.mul_matrix;
        if (mode == 1) begin
            for (int k = 0; k < 64; k++) mo[k*32 +: 32] = 32'(k);
        end
    end
    assign bus.mul_out = mo;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] fbits(input int n);
        int e = 0;
        logic [31:0] m;
        while ((n >> (e + 1)) != 0) e++;
        m = 32'(n) << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    task automatic send_word(input logic [31:0] d);
        int t = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && t < 300) begin step(); t++; end
        if (!bus.in_ready) begin
            bad++;
            $display("FAIL send_word: in_ready stuck low, got %0b want 1", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 300) begin step(); cyc++; end
        if (!bus.out_valid) begin
            bad++;
            $display("FAIL wait_out: out_valid got %0b want 1 within 300 cycles", bus.out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        repeat (3) step();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got %0b want 1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %0b want 0", bus.out_valid); end
        total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got %0b want 0", bus.out_last); end
        total++; if (bus.mul_validin !== 1'b0) begin bad++; $display("FAIL rst_mul_validin got %0b want 0", bus.mul_validin); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %0b want 0", busy); end
`ifdef DCT_SEQ_TIMEOUT_EN
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got %0b want 0", err); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_echo();
        int base, lat;
        mode = 0;
        bus.out_ready = 1'b1;
        base = vin_cnt;
        for (int i = 0; i < 64; i++) send_word(fbits(i + 1));
        lat = 2;
        while (!bus.out_valid && lat < 300) begin step(); lat++; end
        total++; if (lat !== 14) begin bad++; $display("FAIL echo_latency got %0d want 14", lat); end
        total++; if (vin_cnt - base !== 2) begin bad++; $display("FAIL echo_issue_count got %0d want 2", vin_cnt - base); end
        for (int i = 0; i < 64; i++) begin
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== fbits(i + 1) || bus.out_last !== (i == 63)) begin
                bad++;
                $display("FAIL echo_word %0d got v=%0b d=%h l=%0b want v=1 d=%h l=%0b",
                         i, bus.out_valid, bus.out_data, bus.out_last, fbits(i + 1), (i == 63));
            end
            step();
        end
        total++;
        if ({bus.in_ready, busy, bus.out_valid} !== 3'b100) begin
            bad++;
            $display("FAIL echo_after_drain got rdy/busy/vld=%b want 100", {bus.in_ready, busy, bus.out_valid});
        end
    endtask

    task automatic test_transpose();
        int t, cyc;
        mode = 1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 64; i++) send_word(32'h100 + 32'(i));
        total++; if (bus.mul_validin !== 1'b1) begin bad++; $display("FAIL tr_issue1 got %0b want 1", bus.mul_validin); end
        for (int k = 0; k < 64; k++) begin
            total++;
            if (bus.mul_matrix[k*32 +: 32] !== 32'h100 + 32'(k)) begin
                bad++;
                $display("FAIL tr_load word %0d got %h want %h", k, bus.mul_matrix[k*32 +: 32], 32'h100 + 32'(k));
            end
        end
        step();
        total++; if (bus.mul_validin !== 1'b0) begin bad++; $display("FAIL tr_pulse_width got %0b want 0", bus.mul_validin); end
        t = 0;
        while (!bus.mul_validin && t < 50) begin step(); t++; end
        total++; if (bus.mul_validin !== 1'b1) begin bad++; $display("FAIL tr_issue2 got %0b want 1", bus.mul_validin); end
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                total++;
                if (bus.mul_matrix[(r*8+c)*32 +: 32] !== 32'(c*8+r)) begin
                    bad++;
                    $display("FAIL tr_pass1 r=%0d c=%0d got %h want %h", r, c, bus.mul_matrix[(r*8+c)*32 +: 32], 32'(c*8+r));
                end
            end
        end
        wait_out(cyc);
        for (int k = 0; k < 64; k++) begin
            total++;
            if (bus.out_data !== 32'((k % 8) * 8 + k / 8)) begin
                bad++;
                $display("FAIL tr_out word %0d got %h want %h", k, bus.out_data, 32'((k % 8) * 8 + k / 8));
            end
            step();
        end
        mode = 0;
    endtask

    task automatic test_stall();
        int cyc, got;
        logic [3:0] pat;
        logic stalled;
        logic [31:0] held;
        mode = 0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 64; i++) send_word(fbits(64 - i));
        wait_out(cyc);
        pat = 4'b1001;
        got = 0;
        cyc = 0;
        stalled = 1'b0;
        held = '0;
        while (got < 64 && cyc < 400) begin
            bus.out_ready = pat[cyc % 4];
            if (stalled) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== held) begin
                    bad++;
                    $display("FAIL stall_hold got v=%0b d=%h want v=1 d=%h", bus.out_valid, bus.out_data, held);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (bus.out_data !== fbits(64 - got) || bus.out_last !== (got == 63)) begin
                    bad++;
                    $display("FAIL stall_word %0d got d=%h l=%0b want d=%h l=%0b",
                             got, bus.out_data, bus.out_last, fbits(64 - got), (got == 63));
                end
                got++;
            end
            stalled = bus.out_valid && !bus.out_ready;
            held = bus.out_data;
            step();
            cyc++;
        end
        bus.out_ready = 1'b1;
        total++; if (got !== 64) begin bad++; $display("FAIL stall_count got %0d want 64", got); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stall_no_dup got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_gaps_spur();
        int base, cyc;
        mode = 0;
        bus.out_ready = 1'b1;
        base = vin_cnt;
        for (int i = 0; i < 64; i++) begin
            repeat ($urandom_range(0, 2)) step();
            if (i == 10 || i == 40) begin
                spur = 1'b1;
                step();
                spur = 1'b0;
            end
            if (i == 63) begin
                total++;
                if (vin_cnt != base || {bus.in_ready, busy, bus.mul_validin} !== 3'b110) begin
                    bad++;
                    $display("FAIL gap_spur_ignored got issues=%0d rdy/busy/vin=%b want 0 110",
                             vin_cnt - base, {bus.in_ready, busy, bus.mul_validin});
                end
            end
            send_word(32'h5000 + 32'(i * 7));
        end
        wait_out(cyc);
        for (int i = 0; i < 64; i++) begin
            total++;
            if (bus.out_data !== 32'h5000 + 32'(i * 7)) begin
                bad++;
                $display("FAIL gap_word %0d got %h want %h", i, bus.out_data, 32'h5000 + 32'(i * 7));
            end
            step();
        end
    endtask

    task automatic test_reset_wait1();
        int vo, vi;
        mode = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 64; i++) send_word(32'(i));
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({bus.in_ready, busy, bus.out_valid, bus.mul_validin} !== 4'b1000) begin
            bad++;
            $display("FAIL rstw_state got rdy/busy/vld/vin=%b want 1000", {bus.in_ready, busy, bus.out_valid, bus.mul_validin});
        end
        vo = 0;
        vi = 0;
        repeat (20) begin
            step();
            if (bus.out_valid) vo++;
            if (bus.mul_validin) vi++;
        end
        total++; if (vo !== 0) begin bad++; $display("FAIL rstw_no_output got %0d want 0", vo); end
        total++; if (vi !== 0) begin bad++; $display("FAIL rstw_no_issue got %0d want 0", vi); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstw_idle_busy got %0b want 0", busy); end
    endtask

`ifdef DCT_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        mode = 2;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 64; i++) send_word(32'(i));
        repeat (16) step();
        total++; if ({err, bus.in_ready} !== 2'b00) begin bad++; $display("FAIL to_early got err/rdy=%b want 00", {err, bus.in_ready}); end
        step();
        total++;
        if ({err, bus.in_ready, busy} !== 3'b110) begin
            bad++;
            $display("FAIL to_fire got err/rdy/busy=%b want 110", {err, bus.in_ready, busy});
        end
        mode = 0;
        for (int i = 0; i < 64; i++) send_word(fbits(i + 1));
        wait_out(cyc);
        for (int i = 0; i < 64; i++) begin
            total++;
            if (bus.out_data !== fbits(i + 1)) begin
                bad++;
                $display("FAIL to_recover word %0d got %h want %h", i, bus.out_data, fbits(i + 1));
            end
            step();
        end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL to_sticky got %0b want 1", err); end
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_echo();
        test_transpose();
        test_stall();
        test_gaps_spur();
        test_reset_wait1();
`ifdef DCT_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
